// File: rtl/mission_pkg.sv
// Shared types and constants for the mission-level sequencer: FSM states,
// status codes, per-level enable masks and the user switch-off allowances.
package mission_pkg;

  localparam int unsigned MAX_UNITS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_EVAL,
    S_L2_EVAL,
    S_L2_USER,
    S_L3_EVAL,
    S_L3_USER,
    S_FINISH
  } state_e;

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_SUCCESS = 2'b01;
  localparam logic [1:0] STAT_ABORT   = 2'b10;
  localparam logic [1:0] STAT_FAIL    = 2'b11;

  // Units the user may switch off after each level (bit 0 = last unit).
  localparam logic [MAX_UNITS-1:0] L2_OFF_ALLOW = 32'h0000_0002;
  localparam logic [MAX_UNITS-1:0] L3_OFF_ALLOW = 32'h0000_0006;

  // Enable mask for a level: all-ones shifted left by the level number.
  function automatic logic [MAX_UNITS-1:0] level_mask(input int unsigned lvl);
    return {MAX_UNITS{1'b1}} << lvl;
  endfunction

endpackage

// File: rtl/mission_delay_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
module mission_delay_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mission_level_sequencer.sv
// Escalates the fault-tolerance check through Levels 1-3, arming each level
// evaluator, sampling its pass flag and running the user switch-off handshakes.
module mission_level_sequencer
  import mission_pkg::*;
#(
  parameter int unsigned NUNITS        = 5,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned USER_TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUNITS-1:0] unit_ok,
  input  logic              l1_passed,
  input  logic              l2_passed,
  input  logic              l3_passed,
  input  logic              user_valid,
  input  logic [NUNITS-1:0] user_off_req,
  output logic              user_ready,
  output logic [NUNITS-1:0] enable_mask,
  output logic              switch_l2,
  output logic              switch1_l3,
  output logic              switch2_l3,
  output logic [1:0]        level,
  output logic [NUNITS-1:0] out_vec,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  localparam int unsigned CMAX = (SETTLE_CYCLES > USER_TIMEOUT) ? SETTLE_CYCLES : USER_TIMEOUT;
  localparam int unsigned CW   = (CMAX == 0) ? 1 : $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(USER_TIMEOUT);

  state_e            state_q, state_d;
  logic [NUNITS-1:0] snap_q, snap_d;
  logic [NUNITS-1:0] en_q, en_d;
  logic [NUNITS-1:0] off_q, off_d;
  logic [NUNITS-1:0] out_q, out_d;
  logic              sw2_q, sw2_d;
  logic              sw3_q, sw3_d;
  logic [1:0]        status_q, status_d;

  logic              cnt_load;
  logic [CW-1:0]     cnt_val;
  logic              cnt_dec;
  logic              cnt_zero;

  mission_delay_counter #(
    .WIDTH(CW)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    en_d     = en_q;
    off_d    = off_q;
    sw2_d    = sw2_q;
    sw3_d    = sw3_q;
    status_d = status_q;
    cnt_load = 1'b0;
    cnt_val  = SETTLE_LOAD;
    cnt_dec  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d   = unit_ok;
          off_d    = '0;
          status_d = STAT_NONE;
          en_d     = NUNITS'(level_mask(1));
          cnt_load = 1'b1;
          state_d  = S_L1_EVAL;
        end
      end
      S_L1_EVAL: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (l1_passed) begin
          en_d     = NUNITS'(level_mask(2));
          sw2_d    = 1'b1;
          cnt_load = 1'b1;
          state_d  = S_L2_EVAL;
        end else begin
          status_d = STAT_ABORT;
          state_d  = S_FINISH;
        end
      end
      S_L2_EVAL: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (l2_passed) begin
          cnt_load = 1'b1;
          cnt_val  = TIMEOUT_LOAD;
          state_d  = S_L2_USER;
        end else begin
          status_d = STAT_ABORT;
          state_d  = S_FINISH;
        end
      end
      S_L2_USER: begin
        // A handshake on the expiry edge wins, so it is tested first.
        if (user_valid || cnt_zero) begin
          if (user_valid) off_d = off_q | (user_off_req & NUNITS'(L2_OFF_ALLOW));
          en_d     = NUNITS'(level_mask(3));
          sw3_d    = 1'b1;
          cnt_load = 1'b1;
          state_d  = S_L3_EVAL;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_L3_EVAL: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (l3_passed) begin
          cnt_load = 1'b1;
          cnt_val  = TIMEOUT_LOAD;
          state_d  = S_L3_USER;
        end else begin
          status_d = STAT_FAIL;
          state_d  = S_FINISH;
        end
      end
      S_L3_USER: begin
        if (user_valid || cnt_zero) begin
          if (user_valid) off_d = off_q | (user_off_req & NUNITS'(L3_OFF_ALLOW));
          status_d = STAT_SUCCESS;
          state_d  = S_FINISH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Switches drop on the edge that enters FINISH, so an armed level
    // stays armed exactly as long as the mission is still evaluating it.
    if (state_d == S_FINISH) begin
      sw2_d = 1'b0;
      sw3_d = 1'b0;
    end

    out_d = snap_q & en_q & ~off_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      snap_q   <= '0;
      en_q     <= '0;
      off_q    <= '0;
      out_q    <= '0;
      sw2_q    <= 1'b0;
      sw3_q    <= 1'b0;
      status_q <= STAT_NONE;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      en_q     <= en_d;
      off_q    <= off_d;
      out_q    <= out_d;
      sw2_q    <= sw2_d;
      sw3_q    <= sw3_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    level = 2'd0;
    unique case (state_q)
      S_L1_EVAL:            level = 2'd1;
      S_L2_EVAL, S_L2_USER: level = 2'd2;
      S_L3_EVAL, S_L3_USER: level = 2'd3;
      default:              level = 2'd0;
    endcase
  end

  assign user_ready  = (state_q == S_L2_USER) || (state_q == S_L3_USER);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign enable_mask = en_q;
  assign out_vec     = out_q;
  assign switch_l2   = sw2_q;
  assign switch1_l3  = sw3_q;
  assign switch2_l3  = sw3_q;
  assign status      = status_q;

endmodule

// File: tb/tb_mission_level_sequencer.sv
// Directed bench for mission_level_sequencer with hand-computed expectations.
module tb_mission_level_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] unit_ok;
  logic       l1_passed, l2_passed, l3_passed;
  logic       user_valid;
  logic [4:0] user_off_req;
  logic       user_ready;
  logic [4:0] enable_mask;
  logic       switch_l2, switch1_l3, switch2_l3;
  logic [1:0] level;
  logic [4:0] out_vec;
  logic       busy, done;
  logic [1:0] status;

  int tests_run    = 0;
  int tests_failed = 0;
  int sw2_cyc, sw31_cyc, sw32_cyc, rdy_cyc;
  int lat;

  mission_level_sequencer #(
    .NUNITS       (5),
    .SETTLE_CYCLES(1),
    .USER_TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .unit_ok     (unit_ok),
    .l1_passed   (l1_passed),
    .l2_passed   (l2_passed),
    .l3_passed   (l3_passed),
    .user_valid  (user_valid),
    .user_off_req(user_off_req),
    .user_ready  (user_ready),
    .enable_mask (enable_mask),
    .switch_l2   (switch_l2),
    .switch1_l3  (switch1_l3),
    .switch2_l3  (switch2_l3),
    .level       (level),
    .out_vec     (out_vec),
    .busy        (busy),
    .done        (done),
    .status      (status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one mission; lat = rising edges from the start edge to the edge
  // that samples done high (0 if done never arrives).
  task automatic run_mission(input logic [4:0] ok, input logic p1, input logic p2,
                             input logic p3, input logic uv, input logic [4:0] r2,
                             input logic [4:0] r3, output int lat_o);
    int edges;
    l1_passed = p1; l2_passed = p2; l3_passed = p3;
    user_valid = 1'b0;
    start = 1'b1; unit_ok = ok;
    tick();
    start = 1'b0; unit_ok = 5'b00000;
    check_eq("start_mask", {27'd0, enable_mask}, 32'h1E);
    check_eq("start_level", {30'd0, level}, 32'd1);
    check_eq("start_status", {30'd0, status}, 32'd0);
    sw2_cyc = 0; sw31_cyc = 0; sw32_cyc = 0; rdy_cyc = 0;
    edges = 0; lat_o = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        lat_o = edges + 1;
        break;
      end
      user_valid   = uv;
      user_off_req = (level == 2'd3) ? r3 : r2;
      tick();
      edges++;
      if (switch_l2)  sw2_cyc++;
      if (switch1_l3) sw31_cyc++;
      if (switch2_l3) sw32_cyc++;
      if (user_ready) rdy_cyc++;
    end
    user_valid = 1'b0;
    user_off_req = 5'b00000;
    tick();
    check_eq("done_pulse", {31'd0, done}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_level", {30'd0, level}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; unit_ok = '0;
    l1_passed = 1'b0; l2_passed = 1'b0; l3_passed = 1'b0;
    user_valid = 1'b0; user_off_req = '0;
    tick(); tick();
    check_eq("reset_outputs",
             {enable_mask, out_vec, switch_l2, switch1_l3, switch2_l3, user_ready,
              done, busy, level, status}, 32'd0);
    rst = 1'b0;
    tick();

    // L1 fail
    run_mission(5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 5'b0, lat);
    check_eq("l1f_latency", lat, 32'd3);
    check_eq("l1f_status", {30'd0, status}, 32'd2);
    check_eq("l1f_out", {27'd0, out_vec}, 32'h1E);
    check_eq("l1f_sw2", sw2_cyc, 32'd0);

    // L2 fail
    run_mission(5'b11111, 1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 5'b0, lat);
    check_eq("l2f_latency", lat, 32'd5);
    check_eq("l2f_sw2_cycles", sw2_cyc, 32'd2);
    check_eq("l2f_sw2_cleared", {31'd0, switch_l2}, 32'd0);
    check_eq("l2f_status", {30'd0, status}, 32'd2);
    check_eq("l2f_out", {27'd0, out_vec}, 32'h1C);

    // Full success with user answering on the first USER cycle
    run_mission(5'b10111, 1'b1, 1'b1, 1'b1, 1'b1, 5'b00110, 5'b00100, lat);
    check_eq("ok_latency", lat, 32'd9);
    check_eq("ok_status", {30'd0, status}, 32'd1);
    check_eq("ok_out", {27'd0, out_vec}, 32'h10);
    check_eq("ok_mask", {27'd0, enable_mask}, 32'h18);
    check_eq("ok_sw2_cycles", sw2_cyc, 32'd6);
    check_eq("ok_sw3_cycles", sw31_cyc, 32'd3);
    check_eq("ok_rdy_cycles", rdy_cyc, 32'd2);

    // Full success, user silent: both USER states time out
    run_mission(5'b11011, 1'b1, 1'b1, 1'b1, 1'b0, 5'b0, 5'b0, lat);
    check_eq("to_latency", lat, 32'd25);
    check_eq("to_rdy_cycles", rdy_cyc, 32'd18);
    check_eq("to_status", {30'd0, status}, 32'd1);
    check_eq("to_out", {27'd0, out_vec}, 32'h18);

    // L3 fail
    run_mission(5'b01111, 1'b1, 1'b1, 1'b0, 1'b1, 5'b0, 5'b0, lat);
    check_eq("l3f_latency", lat, 32'd8);
    check_eq("l3f_sw31_cycles", sw31_cyc, 32'd2);
    check_eq("l3f_sw32_cycles", sw32_cyc, 32'd2);
    check_eq("l3f_status", {30'd0, status}, 32'd3);
    check_eq("l3f_out", {27'd0, out_vec}, 32'h08);
    check_eq("l3f_sw_cleared", {30'd0, switch1_l3, switch2_l3}, 32'd0);

    // Start while busy ignored, then reset during L3_EVAL
    l1_passed = 1'b1; l2_passed = 1'b1; l3_passed = 1'b1;
    start = 1'b1; unit_ok = 5'b11111;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && level != 2'd2; i++) tick();
    start = 1'b1; unit_ok = 5'b00000;
    tick();
    start = 1'b0;
    check_eq("busy_start_level", {30'd0, level}, 32'd2);
    check_eq("busy_start_mask", {27'd0, enable_mask}, 32'h1C);
    check_eq("busy_start_out", {27'd0, out_vec}, 32'h1C);
    user_valid = 1'b1;
    for (int i = 0; i < 40 && level != 2'd3; i++) tick();
    user_valid = 1'b0;
    check_eq("reach_l3", {30'd0, level}, 32'd3);
    rst = 1'b1;
    #1;
    check_eq("midrst_outputs",
             {enable_mask, out_vec, switch_l2, switch1_l3, switch2_l3, user_ready,
              done, busy, level, status}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("midrst_no_done", {30'd0, done, busy}, 32'd0);
    end

    run_mission(5'b11111, 1'b1, 1'b1, 1'b1, 1'b1, 5'b0, 5'b0, lat);
    check_eq("post_rst_latency", lat, 32'd9);
    check_eq("post_rst_status", {30'd0, status}, 32'd1);
    check_eq("post_rst_out", {27'd0, out_vec}, 32'h18);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
